// File: rtl/regfile_scrub.sv
// Register file with two combinational read ports, one write port and an internal
// zero-scrub engine instead of per-flop reset. Optional forwarding: REGFILE_BYPASS_EN.

module regfile_scrub_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] arr_data,
    input  logic            ready,
    input  logic            byp_hit,
    input  logic [XLEN-1:0] byp_data,
    output logic [XLEN-1:0] data
);
    // Never expose array contents before the scrub has finished.
    always_comb begin
        data = '0;
        if (ready && addr != '0) begin
            data = byp_hit ? byp_data : arr_data;
        end
    end
endmodule

module regfile_scrub #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            ready,
    output logic [AW-1:0]   scrub_idx
);
    localparam int NPORTS = 2;

    typedef enum logic {SCRUB, READY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem [NREGS];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        mem_we    = 1'b0;
        mem_waddr = rd;
        mem_wdata = rd_data;
        if (clr) begin
            state_d = SCRUB;
            cnt_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                SCRUB: begin
                    // rst gates the array because it is only clocked, never reset.
                    mem_we    = rst;
                    mem_waddr = cnt_q;
                    mem_wdata = '0;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end
                end
                READY: begin
                    mem_we = rst && we && (rd != '0);
                end
                default: begin
                    state_d = SCRUB;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCRUB;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [NPORTS-1:0][AW-1:0]   rs_addr;
    logic [NPORTS-1:0][XLEN-1:0] rs_rdata;
    logic [NPORTS-1:0]           rs_byp;

    assign rs_addr = {rs2, rs1};

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
        assign rs_byp[p] = we && (rd != '0) && (rs_addr[p] == rd);
`else
        assign rs_byp[p] = 1'b0;
`endif
        regfile_scrub_rdport #(.XLEN(XLEN), .AW(AW)) u_port (
            .addr     (rs_addr[p]),
            .arr_data (mem[rs_addr[p]]),
            .ready    (ready_q),
            .byp_hit  (rs_byp[p]),
            .byp_data (rd_data),
            .data     (rs_rdata[p])
        );
    end

    assign rs1_data  = rs_rdata[0];
    assign rs2_data  = rs_rdata[1];
    assign ready     = ready_q;
    assign scrub_idx = cnt_q;
endmodule

// File: tb/tb_regfile_scrub.sv
// Randomized bench for regfile_scrub against a behavioural array model; also
// exercises a reduced XLEN=16/NREGS=8 instance for scrub length.

module tb_regfile_scrub;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        rst, clr, we;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rd_data;
    logic [31:0] rs1_data, rs2_data;
    logic        ready;
    logic [4:0]  scrub_idx;

    logic        s_clr, s_we;
    logic [2:0]  s_rd, s_rs1, s_rs2, s_idx;
    logic [15:0] s_wdata, s_rs1_data, s_rs2_data;
    logic        s_ready;

    int n_chk = 0;
    int n_fail = 0;

    // behavioural model: contents, ready flag, edges walked since scrub start
    logic [31:0] model [NREGS];
    logic        m_ready;
    int          m_walk;

    regfile_scrub #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .rd(rd), .rd_data(rd_data),
        .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ready(ready), .scrub_idx(scrub_idx)
    );

    regfile_scrub #(.XLEN(16), .NREGS(8)) u_small (
        .clk(clk), .rst(rst), .clr(s_clr), .we(s_we), .rd(s_rd), .rd_data(s_wdata),
        .rs1(s_rs1), .rs2(s_rs2), .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
        .ready(s_ready), .scrub_idx(s_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        m_ready = 1'b0;
        m_walk  = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0 || !m_ready) ? 32'h0 : model[a];
`ifdef REGFILE_BYPASS_EN
        if (m_ready && we && rd != 5'd0 && a == rd) v = rd_data;
`endif
        return v;
    endfunction

    function automatic logic [4:0] exp_idx();
        return m_ready ? 5'd0 : 5'(m_walk);
    endfunction

    // Apply the edge's rules to the model, then advance past the edge.
    task automatic tick();
        if (!rst) model_clear();
        else if (clr) model_clear();
        else if (!m_ready) begin
            m_walk++;
            if (m_walk == NREGS) m_ready = 1'b1;
        end else if (we && rd != 5'd0) model[rd] = rd_data;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 0; we = 0; rd = 0; rd_data = 0; rs1 = 0; rs2 = 0;
        s_clr = 0; s_we = 0; s_rd = 0; s_wdata = 0; s_rs1 = 0; s_rs2 = 0;
        model_clear();
        repeat (3) tick();
        n_chk++;
        if (ready !== 1'b0 || scrub_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b idx=%0d required ready=0 idx=0", ready, scrub_idx);
        end
        rst = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            #1;
            n_chk++;
            if (ready !== 1'b0 || scrub_idx !== 5'(i)) begin
                n_fail++;
                $display("FAIL scrub_walk[%0d]: ready=%b idx=%0d required ready=0 idx=%0d", i, ready, scrub_idx, i);
            end
            n_chk++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                n_fail++;
                $display("FAIL scrub_read[%0d]: rs1=%h rs2=%h required 0", i, rs1_data, rs2_data);
            end
            n_chk++;
            if (s_ready !== (i >= 8)) begin
                n_fail++;
                $display("FAIL small_ready[%0d]: %b required %b", i, s_ready, (i >= 8));
            end
            tick();
        end
        n_chk++;
        if (ready !== 1'b1 || scrub_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL ready_rise: ready=%b idx=%0d required ready=1 idx=0", ready, scrub_idx);
        end
    endtask

    task automatic test_write_during_scrub();
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            we = (i == 9); rd = 5'd5; rd_data = 32'hDEADBEEF;
            tick();
        end
        we = 1'b0; rs1 = 5'd5;
        #1;
        n_chk++;
        if (ready !== 1'b1 || rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL scrub_write_blocked: ready=%b rs1_data=%h required ready=1 data=0", ready, rs1_data);
        end
    endtask

    task automatic test_normal();
        we = 1'b1; rd = 5'd7; rd_data = 32'h12345678; tick();
        we = 1'b0; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        n_chk++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_read: rs1=%h rs2=%h required 12345678", rs1_data, rs2_data);
        end
        we = 1'b1; rd = 5'd0; rd_data = 32'hFFFFFFFF; tick();
        we = 1'b0; rs1 = 5'd0;
        #1;
        n_chk++;
        if (rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_zero: rs1=%h required 0", rs1_data);
        end
    endtask

    task automatic test_clr();
        for (int i = 1; i < NREGS; i++) begin
            we = 1'b1; rd = 5'(i); rd_data = 32'(i * 32'h11); tick();
        end
        we = 1'b0; rs1 = 5'd31; rs2 = 5'd1;
        #1;
        n_chk++;
        if (rs1_data !== 32'h0000_020F || rs2_data !== 32'h11) begin
            n_fail++;
            $display("FAIL preclr_read: rs1=%h rs2=%h required 0000020f 00000011", rs1_data, rs2_data);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        n_chk++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_drop: ready=%b required 0", ready);
        end
        for (int i = 0; i < NREGS; i++) tick();
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_rescrub_ready: ready=%b required 1", ready);
        end
        for (int i = 0; i < NREGS; i++) begin
            rs1 = 5'(i); rs2 = 5'(NREGS - 1 - i);
            #1;
            n_chk++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                n_fail++;
                $display("FAIL clr_cleared[%0d]: rs1=%h rs2=%h required 0", i, rs1_data, rs2_data);
            end
        end
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (12) tick();
        n_chk++;
        if (scrub_idx !== 5'd12) begin
            n_fail++;
            $display("FAIL clr_mid_idx: idx=%0d required 12", scrub_idx);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            #1;
            n_chk++;
            if (ready !== 1'b0 || scrub_idx !== 5'(i)) begin
                n_fail++;
                $display("FAIL clr_restart[%0d]: ready=%b idx=%0d required 0/%0d", i, ready, scrub_idx, i);
            end
            tick();
        end
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_restart_ready: ready=%b required 1", ready);
        end
    endtask

    task automatic test_async_reset();
        we = 1'b1; rd = 5'd3; rd_data = 32'h33; tick();
        rd_data = 32'hCAFEF00D;
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if (ready !== 1'b0 || scrub_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b idx=%0d required 0/0", ready, scrub_idx);
        end
        model_clear();
        tick();
        we = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NREGS; i++) tick();
        rs1 = 5'd3;
        #1;
        n_chk++;
        if (ready !== 1'b1 || rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_clear: ready=%b rs1=%h required 1/0", ready, rs1_data);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; rd = 5'd9; rd_data = 32'h11112222; tick();
        rd_data = 32'hA5A5A5A5; rs1 = 5'd9; rs2 = 5'd9;
        #1;
        n_chk++;
`ifdef REGFILE_BYPASS_EN
        if (rs1_data !== 32'hA5A5A5A5) begin
`else
        if (rs1_data !== 32'h11112222) begin
`endif
            n_fail++;
            $display("FAIL bypass_same_cycle: rs1=%h model=%h", rs1_data, exp_read(5'd9));
        end
        tick();
        we = 1'b0;
        #1;
        n_chk++;
        if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_after_edge: rs1=%h rs2=%h required a5a5a5a5", rs1_data, rs2_data);
        end
    endtask

    task automatic test_small();
        s_we = 1'b1; s_rd = 3'd3; s_wdata = 16'hBEEF; tick();
        s_we = 1'b1; s_rd = 3'd0; s_wdata = 16'h1234; tick();
        s_we = 1'b0; s_rs1 = 3'd3; s_rs2 = 3'd0;
        #1;
        n_chk++;
        if (s_ready !== 1'b1 || s_rs1_data !== 16'hBEEF || s_rs2_data !== 16'h0) begin
            n_fail++;
            $display("FAIL small_rw: ready=%b rs1=%h rs2=%h required 1 beef 0", s_ready, s_rs1_data, s_rs2_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            clr = ($urandom_range(0, 59) == 0);
            we  = $urandom_range(0, 1);
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rd_data = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            rs2 = 5'($urandom);
            #1;
            n_chk++;
            if (ready !== m_ready || scrub_idx !== exp_idx()) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: ready=%b idx=%0d required %b/%0d", c, ready, scrub_idx, m_ready, exp_idx());
            end
            n_chk++;
            if (rs1_data !== exp_read(rs1)) begin
                n_fail++;
                $display("FAIL rand_rs1[%0d]: addr=%0d got %h required %h", c, rs1, rs1_data, exp_read(rs1));
            end
            n_chk++;
            if (rs2_data !== exp_read(rs2)) begin
                n_fail++;
                $display("FAIL rand_rs2[%0d]: addr=%0d got %h required %h", c, rs2, rs2_data, exp_read(rs2));
            end
            tick();
        end
        clr = 1'b0; we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_small();
        test_write_during_scrub();
        test_normal();
        test_bypass();
        test_clr();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scrub.md
Name: regfile_scrub

Overview:
- Parametrised successor to the single-bank register file: XLEN-bit registers, NREGS entries, two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Contents are cleared by an internal sequential scrub engine, not by a per-flop reset, so the array can map onto distributed RAM.
- Sits between decode (read ports) and writeback (write port) in the CPU datapath.

Parameters:
XLEN, 32, register data width in bits (>=8)
NREGS, 32, number of registers; power of two, 4..64
AW, $clog2(NREGS), address width; derived, do not override

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
clr  input  1  synchronous request to re-run the scrub; sampled on rising edge
we  input  1  write enable
rd  input  AW  write address
rd_data  input  XLEN  write data
rs1  input  AW  read port 1 address
rs2  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data
rs2_data  output  XLEN  read port 2 data
ready  output  1  1 = array initialised, writes accepted, reads valid
scrub_idx  output  AW  current scrub pointer (debug/status)

Behaviour:
- FSM states: SCRUB, READY. The array itself has no reset.
- While rst=0, asynchronously: state=SCRUB, cnt=0, ready=0, scrub_idx=0.
- SCRUB:
  - Each rising edge writes 0 to reg[cnt] and sets cnt<=cnt+1.
  - When cnt==NREGS-1, that edge writes the last entry and moves the FSM to READY.
  - ready therefore rises exactly NREGS rising edges after rst deasserts.
  - cnt wraps to 0 on the exit edge; scrub_idx mirrors cnt.
- READY:
  - On a rising edge with we=1 and rd!=0: reg[rd]<=rd_data.
  - Writes with rd==0 are discarded.
- Reads are combinational:
  - rsN_data = 0 if rsN==0 or ready==0; otherwise reg[rsN].
  - During scrub, reads therefore return 0, never X.
- Write blocking: we is ignored when ready==0 (no buffering, no error flag); the caller must hold off until ready==1.
- clr=1 on a rising edge: next state SCRUB, cnt<=0, ready<=0.
  - Applies from either state; in SCRUB it restarts the walk from 0.
  - A write presented on the same edge as clr is dropped.
- Reset asserted mid-scrub or mid-write: state is forced to SCRUB immediately. A write on an edge coincident with rst=0 is not performed.
- No read-during-write forwarding in the base configuration: a read of rd on the write edge returns the old value until after that edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: if ready==1, we==1, rd!=0 and rsN==rd, then rsN_data=rd_data combinationally in the same cycle (write-to-read forwarding). This removes the writeback hazard stall.
- When undefined: no forwarding; reads return array contents only, as described in Behaviour.

Test Plan:
- Reset release, NREGS=32: hold rst=0 for 3 cycles, release -> ready=0 for 32 rising edges and 1 after the 32nd; scrub_idx counts 0..31 then 0; every read returns 0x00000000.
- Write during scrub: we=1, rd=5, rd_data=0xDEADBEEF at edge 10 after release -> after ready, rs1=5 reads 0x00000000.
- Normal write/read: ready=1, write rd=7 with 0x12345678 -> next cycle rs1=7 and rs2=7 both read 0x12345678. Write rd=0 with 0xFFFFFFFF -> rs1=0 reads 0.
- clr mid-operation: registers 1..31 written with i*0x11, then clr=1 for one edge -> ready=0 next cycle, ready=1 again 32 edges later, all reads return 0. clr asserted again at scrub_idx=12 -> scrub_idx restarts at 0, full 32-edge walk.
- Async reset mid-write: pull rst low between edges while we=1, rd=3 -> ready drops immediately without waiting for an edge; after rescrub, rs1=3 reads 0.
- Bypass check: write rd=9 with 0xA5A5A5A5, rs1=9 in the same cycle -> with REGFILE_BYPASS_EN, rs1_data=0xA5A5A5A5 before the edge; without it, rs1_data shows the old value until after the edge. Parameter sweep XLEN=16, NREGS=8 -> ready after 8 edges.
